mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 27 ++
 rtl/mem_access_lane.sv | 19 +
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the byte-addressed data-memory access unit: FSM states,
// access-type encoding and the default usable address range.
package mem_access_pkg;

  localparam int DEFAULT_LIMIT = 100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Encoding is {write, byte}.
  typedef enum logic [1:0] {
    ACC_LOAD_WORD  = 2'b00,
    ACC_LOAD_BYTE  = 2'b01,
    ACC_STORE_WORD = 2'b10,
    ACC_STORE_BYTE = 2'b11
  } acc_t;

  function automatic acc_t acc_encode(input logic is_write, input logic is_byte);
    return acc_t'({is_write, is_byte});
  endfunction

endpackage

// File: rtl/mem_access_lane.sv
// Data-path lane steering: little-endian word swap, byte extract for loads,
// and read-modify-write byte merge for byte stores.
module mem_access_lane #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   rdata,
  input  logic [WIDTH/2-1:0] wbyte,
  output logic [WIDTH-1:0]   swapped,
  output logic [WIDTH-1:0]   extracted,
  output logic [WIDTH-1:0]   merged
);
  localparam int HW = WIDTH / 2;

  // The byte at the access address sits in the upper half of rdata.
  assign swapped   = {rdata[HW-1:0], rdata[WIDTH-1:HW]};
  assign extracted = {{(WIDTH - HW){1'b0}}, rdata[WIDTH-1:HW]};
  assign merged    = {rdata[HW-1:0], wbyte};

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between a request/response port and a byte-addressed data memory.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN turns misaligned word accesses into errors.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int LIMIT  = DEFAULT_LIMIT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic              REQ_BYTE,
  input  logic [HEIGHT-1:0] REQ_ADDR,
  input  logic [WIDTH-1:0]  REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [WIDTH-1:0]  RSP_RDATA,
  output logic              RSP_ERR,
  output logic              MEM_WE,
  output logic              MEM_RE,
  output logic [HEIGHT-1:0] MEM_ADDR,
  output logic [WIDTH-1:0]  MEM_WDATA,
  input  logic [WIDTH-1:0]  MEM_RDATA,
  output state_t            DBG_STATE
);
  localparam int HW = WIDTH / 2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; once raised, RSP_VALID and its payload hold until that edge.

  state_t          state;
  acc_t            acc_q;
  acc_t            req_acc;
  logic [HW-1:0]   wbyte_q;
  logic            req_err;
  logic [WIDTH-1:0] lane_swap;
  logic [WIDTH-1:0] lane_ext;
  logic [WIDTH-1:0] lane_merge;

  assign req_acc   = acc_encode(REQ_WRITE, REQ_BYTE);
  assign REQ_READY = (state == ST_IDLE);
  assign DBG_STATE = state;

  // Every access touches ADDR+1, so the last usable byte cannot be a start address.
  always_comb begin
    req_err = (REQ_ADDR >= HEIGHT'(LIMIT - 1));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (!REQ_BYTE && REQ_ADDR[0]) req_err = 1'b1;
`endif
  end

  mem_access_lane #(.WIDTH(WIDTH)) u_lane (
    .rdata     (MEM_RDATA),
    .wbyte     (wbyte_q),
    .swapped   (lane_swap),
    .extracted (lane_ext),
    .merged    (lane_merge)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      acc_q     <= ACC_LOAD_WORD;
      wbyte_q   <= '0;
      RSP_VALID <= 1'b0;
      RSP_ERR   <= 1'b0;
      RSP_RDATA <= '0;
      MEM_WE    <= 1'b0;
      MEM_RE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            acc_q    <= req_acc;
            wbyte_q  <= REQ_WDATA[HW-1:0];
            MEM_ADDR <= REQ_ADDR;
            if (req_err) begin
              state     <= ST_RESP;
              RSP_VALID <= 1'b1;
              RSP_ERR   <= 1'b1;
              RSP_RDATA <= '0;
            end else begin
              case (req_acc)
                ACC_STORE_WORD: begin
                  state     <= ST_WR;
                  MEM_WE    <= 1'b1;
                  MEM_WDATA <= REQ_WDATA;
                end
                ACC_STORE_BYTE: begin
                  state  <= ST_RMW_RD;
                  MEM_RE <= 1'b1;
                end
                default: begin
                  state  <= ST_RD;
                  MEM_RE <= 1'b1;
                end
              endcase
            end
          end
        end
        ST_RD: begin
          MEM_RE    <= 1'b0;
          RSP_VALID <= 1'b1;
          RSP_ERR   <= 1'b0;
          RSP_RDATA <= (acc_q == ACC_LOAD_BYTE) ? lane_ext : lane_swap;
          state     <= ST_RESP;
        end
        ST_RMW_RD: begin
          // Merge keeps the neighbouring byte so the word write leaves ADDR+1 intact.
          MEM_RE    <= 1'b0;
          MEM_WE    <= 1'b1;
          MEM_WDATA <= lane_merge;
          state     <= ST_WR;
        end
        ST_WR: begin
          MEM_WE    <= 1'b0;
          RSP_VALID <= 1'b1;
          RSP_ERR   <= 1'b0;
          RSP_RDATA <= '0;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            RSP_RDATA <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array reference model and data memory.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int W     = 16;
  localparam int H     = 16;
  localparam int LIMIT = 100;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic         req_byte;
  logic [H-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_rdata;
  logic         rsp_err;
  logic         mem_we;
  logic         mem_re;
  logic [H-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  state_t       dbg_state;

  mem_access_unit #(.WIDTH(W), .HEIGHT(H), .LIMIT(LIMIT)) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ_VALID (req_valid),
    .REQ_READY (req_ready),
    .REQ_WRITE (req_write),
    .REQ_BYTE  (req_byte),
    .REQ_ADDR  (req_addr),
    .REQ_WDATA (req_wdata),
    .RSP_VALID (rsp_valid),
    .RSP_READY (rsp_ready),
    .RSP_RDATA (rsp_rdata),
    .RSP_ERR   (rsp_err),
    .MEM_WE    (mem_we),
    .MEM_RE    (mem_re),
    .MEM_ADDR  (mem_addr),
    .MEM_WDATA (mem_wdata),
    .MEM_RDATA (mem_rdata),
    .DBG_STATE (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // data memory: byte at MEM_ADDR in the upper half; writes put the low half at MEM_ADDR
  logic [7:0] dmem [0:LIMIT-1];
  assign mem_rdata = (int'(mem_addr) < LIMIT - 1) ?
                     {dmem[int'(mem_addr)], dmem[int'(mem_addr) + 1]} : '0;
  always @(posedge clk) begin
    if (mem_we && int'(mem_addr) < LIMIT - 1) begin
      dmem[int'(mem_addr)]     = mem_wdata[7:0];
      dmem[int'(mem_addr) + 1] = mem_wdata[15:8];
    end
  end

  // reference model and scoreboard
  logic [7:0]  mm [0:LIMIT-1];
  logic [16:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 0;
  bit          busy     = 0;
  logic [W-1:0] last_rd;
  logic         last_err;
  logic [W-1:0] last_wd;
  int           last_lat;
  state_t       st_trace [1:4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(!busy));
      check("mem_en_overlap", 32'(mem_we & mem_re), 32'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          check("rsp_err_data", 32'({rsp_err, rsp_rdata}), 32'(exp_q[0]));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // driver: one request, responds after `hold` cycles of RSP_READY=0
  task automatic do_req(input logic wr, input logic by, input logic [H-1:0] addr,
                        input logic [W-1:0] wd, input int hold);
    logic         e_err;
    logic [W-1:0] e_rd;
    logic [W-1:0] e_wd;
    int           e_lat, e_re, e_we, a;
    int           lat, re_n, we_n;
    bit           seen;
    a = int'(addr);
    e_err = (a >= LIMIT - 1);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (!by && addr[0]) e_err = 1'b1;
`endif
    e_rd = '0; e_wd = '0; e_re = 0; e_we = 0; e_lat = 1;
    if (!e_err) begin
      if (!wr) begin
        e_rd  = by ? {8'h00, mm[a]} : {mm[a + 1], mm[a]};
        e_lat = 2; e_re = 1;
      end else if (by) begin
        e_wd  = {mm[a + 1], wd[7:0]};
        mm[a] = wd[7:0];
        e_lat = 3; e_re = 1; e_we = 1;
      end else begin
        e_wd      = wd;
        mm[a]     = wd[7:0];
        mm[a + 1] = wd[15:8];
        e_lat = 2; e_we = 1;
      end
    end
    exp_q.push_back({e_err, e_rd});

    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_byte = by; req_addr = addr; req_wdata = wd;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    busy = 1;
    lat = 0; re_n = 0; we_n = 0; seen = 0; last_wd = '0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat <= 4) st_trace[lat] = dbg_state;
      if (mem_re) begin
        re_n++;
        check("re_addr", 32'(mem_addr), 32'(addr));
      end
      if (mem_we) begin
        we_n++;
        last_wd = mem_wdata;
        check("we_addr", 32'(mem_addr), 32'(addr));
        check("we_data", 32'(mem_wdata), 32'(e_wd));
      end
      if (rsp_valid) seen = 1;
    end
    if (!seen) begin
      check("rsp_timeout", 32'(seen), 32'd1);
      busy = 0;
      rsp_ready = 1'b0;
      return;
    end
    last_rd = rsp_rdata; last_err = rsp_err; last_lat = lat;
    check("latency", 32'(lat), 32'(e_lat));
    check("re_cycles", 32'(re_n), 32'(e_re));
    check("we_cycles", 32'(we_n), 32'(e_we));
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    busy = 0;
  endtask

  initial begin
    int bad;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < LIMIT; i++) dmem[i] = 8'($urandom_range(0, 255));
    dmem[0] = 8'h99; dmem[1] = 8'hAB; dmem[3] = 8'h3C; dmem[4] = 8'h4D;
    for (int i = 0; i < LIMIT; i++) mm[i] = dmem[i];

    #13;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_mem_en", 32'({mem_we, mem_re}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;

    do_req(1'b0, 1'b0, 16'd0, 16'h0000, 0);
    check("lit_wload0", 32'(last_rd), 32'h0000AB99);
    check("lit_wload0_lat", 32'(last_lat), 32'd2);
    do_req(1'b0, 1'b1, 16'd1, 16'h0000, 0);
    check("lit_bload1", 32'(last_rd), 32'h000000AB);
    do_req(1'b0, 1'b0, 16'd3, 16'h0000, 0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    check("lit_wload3_err", 32'({last_err, last_rd}), 32'h00010000);
`else
    check("lit_wload3", 32'({last_err, last_rd}), 32'h00004D3C);
`endif
    do_req(1'b1, 1'b0, 16'd4, 16'h1234, 0);
    check("lit_wstore4_wdata", 32'(last_wd), 32'h00001234);
    do_req(1'b0, 1'b0, 16'd4, 16'h0000, 0);
    check("lit_wload4", 32'(last_rd), 32'h00001234);
    do_req(1'b1, 1'b1, 16'd0, 16'hFF55, 0);
    check("lit_bstore0_wdata", 32'(last_wd), 32'h0000AB55);
    check("lit_bstore0_lat", 32'(last_lat), 32'd3);
    check("lit_bstore0_st1", 32'(st_trace[1]), 32'(ST_RMW_RD));
    check("lit_bstore0_st2", 32'(st_trace[2]), 32'(ST_WR));
    do_req(1'b0, 1'b0, 16'd0, 16'h0000, 3);
    check("lit_wload0_after", 32'(last_rd), 32'h0000AB55);
    do_req(1'b0, 1'b1, 16'd1, 16'h0000, 0);
    check("lit_byte1_kept", 32'(last_rd), 32'h000000AB);
    do_req(1'b0, 1'b0, 16'd99, 16'h0000, 1);
    check("lit_wload99", 32'({last_err, last_rd}), 32'h00010000);
    check("lit_wload99_lat", 32'(last_lat), 32'd1);
    do_req(1'b0, 1'b1, 16'd99, 16'h0000, 0);
    do_req(1'b1, 1'b1, 16'd99, 16'h00EE, 0);
    do_req(1'b0, 1'b0, 16'd98, 16'h0000, 0);
    do_req(1'b0, 1'b1, 16'd0, 16'h0000, 0);
    check("lit_bload0", 32'(last_rd), 32'h00000055);
    do_req(1'b1, 1'b0, 16'd7, 16'hBEEF, 0);
    do_req(1'b0, 1'b0, 16'd7, 16'h0000, 2);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    check("lit_wload7_err", 32'({last_err, last_rd}), 32'h00010000);
`else
    check("lit_wload7", 32'({last_err, last_rd}), 32'h0000BEEF);
`endif

    // reset pulse while a word store sits in WR
    chk_en = 0;
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 16'd10; req_wdata = 16'h7777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_we_on", 32'(mem_we), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_we_async", 32'(mem_we), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_mem10", 32'({dmem[10], dmem[11]}), 32'({mm[10], mm[11]}));
    check("rst_mid_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    chk_en = 1;
    do_req(1'b0, 1'b0, 16'd10, 16'h0000, 0);

    for (int i = 0; i < 12; i++) begin
      logic         wr_r, by_r;
      logic [H-1:0] a_r;
      logic [W-1:0] d_r;
      wr_r = 1'($urandom_range(0, 1));
      by_r = 1'($urandom_range(0, 1));
      a_r  = 16'($urandom_range(0, LIMIT));
      d_r  = 16'($urandom_range(0, 65535));
      do_req(wr_r, by_r, a_r, d_r, $urandom_range(0, 2));
    end

    bad = 0;
    for (int i = 0; i < LIMIT; i++) if (dmem[i] !== mm[i]) bad++;
    check("mem_final_sweep", 32'(bad), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
